// File: rtl/sram_master_pkg.sv
// Shared types and helpers for the SRAM line master.
package sram_master_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  // Clears the in-line byte offset; callers narrow the result to their address width.
  function automatic logic [63:0] line_base(input logic [63:0] addr,
                                            input int unsigned line_words);
    logic [63:0] mask;
    mask = 64'(line_words) * 64'd4 - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/sram_beat_addr_gen.sv
// Beat counter and read address generator for line fetches.
// Optional CRITICAL_WORD_FIRST_EN starts the beat sequence at the requested word.
module sram_beat_addr_gen
  import sram_master_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32,
  localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_idx,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [IDX_W-1:0]  idx,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] first_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      first_q <= '0;
    end else if (start) begin
      first_q <= start_idx;
    end
  end

  // Index arithmetic wraps naturally at the power-of-two line size.
  assign idx = cnt_q + first_q;
`else
  logic unused_start_idx;
  assign unused_start_idx = ^start_idx;
  assign idx = cnt_q;
`endif

  assign last = (cnt_q == IDX_W'(LINE_WORDS - 1));
  assign addr = base + ADDR_W'({idx, 2'b00});

endmodule

// File: rtl/sram_line_master.sv
// SRAM port initiator: whole-line reads one word per beat, single-word writes.
// CRITICAL_WORD_FIRST_EN (in sram_beat_addr_gen) selects critical-word-first read order.
module sram_line_master
  import sram_master_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wen,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [STRB_W-1:0]            req_wstrb,
  input  logic [WORD_W-1:0]            req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_is_write,
  output logic [WORD_W*LINE_WORDS-1:0] resp_data,
  output logic [ADDR_W-1:0]            sram_raddr,
  output logic                         sram_ren,
  input  logic [WORD_W-1:0]            sram_rdata,
  output logic [ADDR_W-1:0]            sram_waddr,
  output logic                         sram_wen,
  output logic [STRB_W-1:0]            sram_wstrb,
  output logic [WORD_W-1:0]            sram_wdata
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;

  state_e                              state_q, state_d;
  logic [ADDR_W-1:0]                   base_q;
  logic [ADDR_W-1:0]                   waddr_q;
  logic [STRB_W-1:0]                   wstrb_q;
  logic [WORD_W-1:0]                   wdata_q;
  logic                                is_write_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0]   line_q;

  logic              accept;
  logic [ADDR_W-1:0] req_base;
  logic [IDX_W-1:0]  beat_idx;
  logic              beat_last;
  logic [ADDR_W-1:0] beat_addr;

  assign accept   = req_valid & req_ready;
  assign req_base = ADDR_W'(line_base(64'(req_addr), LINE_WORDS));

  sram_beat_addr_gen #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_beat_gen (
    .clock     (clock),
    .reset     (reset),
    .start     (accept & ~req_wen),
    .start_idx (req_addr[OFF_W-1:2]),
    .advance   (state_q == StRead),
    .base      (base_q),
    .idx       (beat_idx),
    .last      (beat_last),
    .addr      (beat_addr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = req_wen ? StWrite : StRead;
      StRead:  if (beat_last) state_d = StResp;
      StWrite: state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      waddr_q    <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_write_q <= req_wen;
        if (req_wen) begin
          waddr_q <= {req_addr[ADDR_W-1:2], 2'b00};
          wstrb_q <= req_wstrb;
          wdata_q <= req_wdata;
        end else begin
          base_q <= req_base;
        end
      end
      if (state_q == StRead) begin
        line_q[beat_idx] <= sram_rdata;
      end
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign resp_valid    = (state_q == StResp);
  assign resp_is_write = is_write_q;
  assign resp_data     = line_q;
  assign sram_ren      = (state_q == StRead);
  assign sram_wen      = (state_q == StWrite);
  // Idle SRAM outputs are held at zero rather than leaking latched values.
  assign sram_raddr    = sram_ren ? beat_addr : '0;
  assign sram_waddr    = sram_wen ? waddr_q : '0;
  assign sram_wstrb    = sram_wen ? wstrb_q : '0;
  assign sram_wdata    = sram_wen ? wdata_q : '0;

endmodule

// File: tb/tb_sram_line_master.sv
// Directed bench for sram_line_master with an SRAM model and a response scoreboard.
module tb_sram_line_master;

  localparam int unsigned LW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32 * LW;

  logic          clock, reset;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_wstrb;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_ready, resp_is_write;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] sram_raddr, sram_waddr;
  logic          sram_ren, sram_wen;
  logic [31:0]   sram_rdata, sram_wdata;
  logic [3:0]    sram_wstrb;

  sram_line_master #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_addr      (req_addr),
    .req_wstrb     (req_wstrb),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_is_write (resp_is_write),
    .resp_data     (resp_data),
    .sram_raddr    (sram_raddr),
    .sram_ren      (sram_ren),
    .sram_rdata    (sram_rdata),
    .sram_waddr    (sram_waddr),
    .sram_wen      (sram_wen),
    .sram_wstrb    (sram_wstrb),
    .sram_wdata    (sram_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // SRAM model (address bits [11:2] index it) and the bench's own reference copy.
  logic [31:0] mem [0:1023];
  logic [31:0] mdl [0:1023];

  always_comb sram_rdata = mem[sram_raddr[11:2]];

  always @(posedge clock) begin
    if (sram_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wstrb[b]) mem[sram_waddr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic          is_write;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ren_log[$];
  int          wen_cnt;
  logic [31:0] wlog_addr, wlog_data;
  logic [3:0]  wlog_strb;

  always @(negedge clock) begin
    if (sram_ren || sram_wen) begin
      checks++;
      assert (!(sram_ren && sram_wen)) else begin
        errors++;
        $error("FAIL ren_wen_excl observed ren=%0b wen=%0b expected not both", sram_ren, sram_wen);
      end
    end
    if (sram_ren) ren_log.push_back(sram_raddr);
    if (sram_wen) begin
      wen_cnt++;
      wlog_addr = sram_waddr;
      wlog_strb = sram_wstrb;
      wlog_data = sram_wdata;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges after the handshake edge until resp_valid, bounded.
  task automatic wait_resp(input int unsigned exp_lat, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!resp_valid && n < 20);
    check({tag, "_latency"}, DW'(n), DW'(exp_lat));
  endtask

  task automatic finish_resp(input string tag, input int hold);
    logic [DW-1:0] snap;
    exp_t e;
    snap = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check({tag, "_hold_valid"}, DW'(resp_valid), DW'(1));
      check({tag, "_hold_data"}, resp_data, snap);
      check({tag, "_hold_ready"}, DW'(req_ready), DW'(0));
      check({tag, "_hold_en"}, DW'({sram_ren, sram_wen}), DW'(0));
    end
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, DW'(0), DW'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_is_write"}, DW'(resp_is_write), DW'(e.is_write));
      if (!e.is_write) check({tag, "_data"}, resp_data, e.data);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, DW'(resp_valid), DW'(0));
    check({tag, "_ready_back"}, DW'(req_ready), DW'(1));
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input int hold);
    exp_t e;
    logic [31:0] base, a;
    int start;
    base = addr & ~32'(LW * 4 - 1);
    e.is_write = 1'b0;
    for (int k = 0; k < LW; k++) begin
      a = base + 32'(4 * k);
      e.data[32*k +: 32] = mdl[a[11:2]];
    end
    exp_q.push_back(e);
`ifdef CRITICAL_WORD_FIRST_EN
    start = int'(addr[3:2]);
`else
    start = 0;
`endif
    ren_log.delete();
    check({tag, "_req_ready"}, DW'(req_ready), DW'(1));
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = addr;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    wait_resp(LW, tag);
    check({tag, "_ren_beats"}, DW'(ren_log.size()), DW'(LW));
    for (int k = 0; k < LW && k < ren_log.size(); k++) begin
      a = base + 32'(4 * ((start + k) % LW));
      check($sformatf("%s_raddr%0d", tag, k), DW'(ren_log[k]), DW'(a));
    end
    finish_resp(tag, hold);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] data);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) mdl[addr[11:2]][8*b +: 8] = data[8*b +: 8];
    end
    e.is_write = 1'b1;
    e.data     = '0;
    exp_q.push_back(e);
    wen_cnt = 0;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = data;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    wait_resp(1, tag);
    check({tag, "_wen_cycles"}, DW'(wen_cnt), DW'(1));
    check({tag, "_waddr"}, DW'(wlog_addr), DW'(addr & ~32'h3));
    check({tag, "_wstrb"}, DW'(wlog_strb), DW'(strb));
    check({tag, "_wdata"}, DW'(wlog_data), DW'(data));
    finish_resp(tag, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hA000_0000 + 32'(i);
      mdl[i] = 32'hA000_0000 + 32'(i);
    end
    mem[10'h82] = 32'h1122_3344;
    mdl[10'h82] = 32'h1122_3344;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wstrb  = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_req_ready", DW'(req_ready), DW'(1));
    check("rst_resp_valid", DW'(resp_valid), DW'(0));
    check("rst_resp_is_write", DW'(resp_is_write), DW'(0));
    check("rst_resp_data", resp_data, DW'(0));
    check("rst_enables", DW'({sram_ren, sram_wen}), DW'(0));
    check("rst_sram_bus", DW'({sram_raddr, sram_waddr, sram_wstrb, sram_wdata}), DW'(0));

    do_read("rd104", 32'h0000_0104, 0);
    do_write("wr208", 32'h0000_0208, 4'b0011, 32'hDEAD_BEEF);
    do_read("rd200", 32'h0000_0200, 0);
    do_read("rd040_hold", 32'h0000_0040, 3);

    // Reset during the third read beat discards the line.
    ren_log.delete();
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h0000_0300;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_ren", DW'(sram_ren), DW'(0));
    check("abort_req_ready", DW'(req_ready), DW'(1));
    check("abort_beats", DW'(ren_log.size()), DW'(3));
    repeat (4) begin
      @(posedge clock);
      #1;
      check("abort_no_resp", DW'(resp_valid), DW'(0));
    end

    do_read("rd300", 32'h0000_0300, 0);
    do_read("rd10c", 32'h0000_010C, 0);
    do_read("rd_top", 32'hFFFF_FFF0, 0);
    do_read("rd_top_f8", 32'hFFFF_FFF8, 0);
    do_write("wr_nostrb", 32'h0000_0304, 4'b0000, 32'h5555_AAAA);
    do_read("rd300_after", 32'h0000_0300, 1);

    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_line_master.md
Name: sram_line_master

Overview:
- Initiator side of the simulation SRAM port. Accepts core/cache requests over a valid/ready handshake and drives the SRAM read/write port (raddr, waddr, ren, wen, wstrb, wdata).
- A read fetches a whole cache line, one 32-bit word per cycle, and assembles it. A write is a single word.
- Sits between the I/D-cache refill/store logic and the SRAM model in unit-test and SoC benches.

Parameters:
- LINE_WORDS, 4: words per line; power of two, ≥2.
- ADDR_W, 32: request and SRAM address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  block can accept a request
- req_wen  in  1  1 = word write, 0 = line read
- req_addr  in  ADDR_W  byte address
- req_wstrb  in  4  byte enables for writes
- req_wdata  in  32  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts the response
- resp_is_write  out  1  response acknowledges a write
- resp_data  out  32*LINE_WORDS  line data; word 0 is in bits [31:0]
- sram_raddr  out  ADDR_W  SRAM read address
- sram_ren  out  1  SRAM read enable
- sram_rdata  in  32  SRAM read data, combinational from sram_raddr in the same cycle
- sram_waddr  out  ADDR_W  SRAM write address
- sram_wen  out  1  SRAM write enable
- sram_wstrb  out  4  SRAM byte strobes
- sram_wdata  out  32  SRAM write data

Behaviour:
- Clocking/reset:
  - Single clock domain. Reset is synchronous and active-high. Ports are named clock and reset.
  - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_is_write=0, resp_data=0, sram_ren=0, sram_wen=0, all sram address/data/strobe outputs=0, beat counter=0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. A handshake (req_valid & req_ready) latches the request.
  - Read → READ, beat=0, base = req_addr with the low log2(LINE_WORDS)+2 bits cleared.
  - Write → WRITE, latching addr (low 2 bits cleared), wstrb, wdata.
- READ:
  - sram_ren=1 and sram_raddr = base + 4*beat.
  - At the clock edge, sram_rdata is captured into line word[beat] and beat increments.
  - When beat==LINE_WORDS-1 the state moves to RESP.
  - Exactly LINE_WORDS consecutive ren cycles, no bubbles.
- WRITE:
  - One cycle with sram_wen=1, sram_waddr/wstrb/wdata from the latched request. Then → RESP.
  - wstrb=0 still issues the cycle; the SRAM is unchanged.
- RESP:
  - resp_valid=1. resp_is_write reflects the request type.
  - resp_data holds the line for reads. For writes resp_data holds its previous value and must be ignored.
  - Response fields are stable while resp_valid & !resp_ready.
  - On resp_ready the state goes to IDLE the next cycle.
- Outside their own state: sram_ren=0, sram_wen=0, req_ready=0.
- Latency: request accepted at edge T.
  - Read: resp_valid from cycle T+LINE_WORDS+1.
  - Write: resp_valid from cycle T+2.
- No request bypass: req_ready is 0 in RESP even when resp_ready=1. Peak read throughput is one line per LINE_WORDS+2 cycles.
- Address arithmetic is modulo 2^ADDR_W; a line at the top of the address space wraps to 0.
- req_valid while req_ready=0 has no effect; the request must be held by the source.
- Reset mid-operation: the next state is IDLE, any partial line is discarded, and sram_ren/sram_wen drop in the cycle after reset is sampled.
- sram_ren and sram_wen are never high together.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined: the read beat sequence starts at word index req_addr[log2(LINE_WORDS)+1:2] and wraps modulo LINE_WORDS. Each word is still stored at its natural position in resp_data.
- Undefined: beats always run 0..LINE_WORDS-1.
- Latency is identical in both cases.

Decomposition:
- Package sram_master_pkg:
  - state enum (IDLE, READ, WRITE, RESP)
  - WORD_W=32, STRB_W=4
  - function line_base(addr, LINE_WORDS)
- One natural sub-module: sram_beat_addr_gen. It holds the beat counter, the wrap logic (including the CRITICAL_WORD_FIRST_EN variant), last-beat detect and the address output.

Test Plan:
- SRAM preloaded with word i = 0xA000_0000+i. Read req_addr=0x104, LINE_WORDS=4 → ren for 4 cycles at 0x100,0x104,0x108,0x10C; resp_data={0xA..43,0xA..42,0xA..41,0xA..40}; resp_valid at T+5.
- Write addr 0x208, wstrb=4'b0011, wdata=0xDEADBEEF over old 0x11223344 → one wen cycle; subsequent line read returns word 0x1122BEEF; resp_is_write=1 at T+2.
- Hold resp_ready=0 for 3 cycles in RESP → resp_valid and resp_data stable, req_ready=0, no SRAM enables.
- Assert reset during READ beat 2 → IDLE next cycle, ren=0, resp_valid never rises; a new read of 0x300 completes correctly.
- With CRITICAL_WORD_FIRST_EN, read 0x10C → raddr order 0x10C,0x100,0x104,0x108; resp_data identical to the non-CWF run.
- Read at 0xFFFF_FFF0 → beats 0xFFFF_FFF0..0xFFFF_FFFC; with CWF and addr 0xFFFF_FFF8, wraps to 0xFFFF_FFF0 and not to 0x0.
